axis_s_pkt_collector: RTL and testbench

AXI-Stream slave that sits directly downstream of the byte-wide AXI-Stream master stage. It accepts beats and packs each packet, delimited by `s_axis_tlast`, into one parallel word. It presents that word with its length, a byte checksum and an overflow flag on a valid/ready packet port. While a completed packet is unclaimed, it backpressures the stream.

---
 rtl/axis_pkg.sv | 21 ++
 rtl/axis_s_pkt_collector.sv | 160 ++++++++++++++++
 tb/tb_axis_s_pkt_collector.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the byte-wide AXI-Stream master stage and the packet
// collector that sits downstream of it.
//   AXIS_DATA_W     default beat width in bits
//   AXIS_PKT_BEATS  default packet length in beats (master stage emits packets
//                   of this length; the collector stores this many beats)
//   collect_state_t collector FSM states
// -----------------------------------------------------------------------------
package axis_pkg;

    localparam int AXIS_DATA_W    = 8;
    localparam int AXIS_PKT_BEATS = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } collect_state_t;

endpackage

// File: rtl/axis_s_pkt_collector.sv
// -----------------------------------------------------------------------------
// axis_s_pkt_collector
// AXI-Stream slave that packs each tlast-delimited packet into one parallel
// word and offers it, with beat count, byte sum and truncation flag, on a
// valid/ready packet port. The stream is backpressured while a completed
// packet waits to be taken.
//
// Ports
//   s_axis_aclk    in   clock, all logic on rising edge
//   s_axis_areset  in   synchronous active-high reset
//   s_axis_tvalid  in   beat valid
//   s_axis_tready  out  beat accept (decoded from state, low during reset)
//   s_axis_tdata   in   beat data, DATA_W bits
//   s_axis_tlast   in   last beat of packet
//   pkt_valid      out  completed packet available
//   pkt_ready      in   consumer takes the packet
//   pkt_data       out  beat i at [i*DATA_W +: DATA_W], unused lanes zero
//   pkt_len        out  beats stored, 1..MAX_BEATS
//   pkt_sum        out  unsigned sum of stored beats
//   pkt_err        out  packet was longer than MAX_BEATS and got truncated
// -----------------------------------------------------------------------------
module axis_s_pkt_collector
    import axis_pkg::*;
#(
    parameter int DATA_W    = AXIS_DATA_W,
    parameter int MAX_BEATS = AXIS_PKT_BEATS,
    parameter int LEN_W     = $clog2(MAX_BEATS + 1),
    parameter int SUM_W     = DATA_W + LEN_W
) (
    input  logic                        s_axis_aclk,
    input  logic                        s_axis_areset,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [DATA_W-1:0]           s_axis_tdata,
    input  logic                        s_axis_tlast,
    output logic                        pkt_valid,
    input  logic                        pkt_ready,
    output logic [MAX_BEATS*DATA_W-1:0] pkt_data,
    output logic [LEN_W-1:0]            pkt_len,
    output logic [SUM_W-1:0]            pkt_sum,
    output logic                        pkt_err
);

    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_BEATS - 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(MAX_BEATS);

    collect_state_t              state_q;
    collect_state_t              state_d;
    logic [MAX_BEATS*DATA_W-1:0] lanes_q;
    logic [LEN_W-1:0]            idx_q;
    logic [SUM_W-1:0]            sum_q;
    logic [LEN_W-1:0]            len_q;
    logic                        err_q;
    logic                        valid_q;
    logic                        beat_acc;

    // idx stops at the last lane so a lane write can never run off the word.
    function automatic logic [LEN_W-1:0] idx_sat_inc(input logic [LEN_W-1:0] i);
        return (i == LAST_IDX) ? i : i + 1'b1;
    endfunction

    // Zero-extended accumulate; SUM_W holds MAX_BEATS full-scale beats.
    function automatic logic [SUM_W-1:0] sum_add(input logic [SUM_W-1:0]  s,
                                                 input logic [DATA_W-1:0] d);
        return s + {{LEN_W{1'b0}}, d};
    endfunction

    assign s_axis_tready = (state_q != HOLD) && !s_axis_areset;
    assign beat_acc      = s_axis_tvalid && s_axis_tready;

    // State register
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: begin
                if (beat_acc) begin
                    if (s_axis_tlast) begin
                        state_d = HOLD;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (beat_acc && s_axis_tlast) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (pkt_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Datapath: lanes, index, sum, length, error and packet valid
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            lanes_q <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (beat_acc) begin
                        lanes_q[idx_q*DATA_W +: DATA_W] <= s_axis_tdata;
                        sum_q <= sum_add(sum_q, s_axis_tdata);
                        idx_q <= idx_sat_inc(idx_q);
                        if (s_axis_tlast) begin
                            len_q   <= idx_q + 1'b1;
                            err_q   <= 1'b0;
                            valid_q <= 1'b1;
                        end else if (idx_q == LAST_IDX) begin
                            err_q   <= 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    // Overflow beats are swallowed; stored lanes and sum stay put.
                    if (beat_acc && s_axis_tlast) begin
                        len_q   <= FULL_LEN;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (pkt_ready) begin
                        lanes_q <= '0;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pkt_valid = valid_q;
    assign pkt_data  = lanes_q;
    assign pkt_len   = len_q;
    assign pkt_sum   = sum_q;
    assign pkt_err   = err_q;

endmodule

// File: tb/tb_axis_s_pkt_collector.sv
module tb_axis_s_pkt_collector;
    import axis_pkg::*;

    localparam int BEAT_LIMIT = 500;
    localparam int PKT_LIMIT  = 3000;

    logic        s_axis_aclk = 1'b0;
    logic        s_axis_areset;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tlast;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] pkt_data;
    logic [2:0]  pkt_len;
    logic [10:0] pkt_sum;
    logic        pkt_err;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  len;
        logic [10:0] sum;
        logic        err;
        int          vc;
    } pkt_t;

    pkt_t       got_q[$];
    pkt_t       exp_q[$];
    int         n_cmp = 0;
    int         n_mis = 0;
    int         vcyc  = 0;
    logic [7:0] beats[0:7];
    int         waits_a[0:7];
    bit         rnd_done;

    axis_s_pkt_collector dut (
        .s_axis_aclk   (s_axis_aclk),
        .s_axis_areset (s_axis_areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .pkt_data      (pkt_data),
        .pkt_len       (pkt_len),
        .pkt_sum       (pkt_sum),
        .pkt_err       (pkt_err)
    );

    always #5 s_axis_aclk = ~s_axis_aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Packet port monitor: a packet is taken when valid and ready are both
    // high ahead of a rising edge; pkt_ready only changes just after an edge.
    always @(negedge s_axis_aclk) begin
        if (s_axis_areset) begin
            vcyc = 0;
        end else if (pkt_valid) begin
            vcyc++;
            check("no_accept_while_valid", s_axis_tready, 1'b0);
            if (pkt_ready) begin
                got_q.push_back('{data: pkt_data, len: pkt_len, sum: pkt_sum,
                                  err: pkt_err, vc: vcyc});
                vcyc = 0;
            end
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic [2:0] l,
                            input logic [10:0] s, input logic e);
        exp_q.push_back('{data: d, len: l, sum: s, err: e, vc: 0});
    endtask

    // Expected packet from the first n entries of beats[].
    task automatic push_model(input int n);
        logic [31:0] d;
        logic [10:0] s;
        d = '0;
        s = '0;
        for (int i = 0; i < n && i < 4; i++) begin
            d[i*8 +: 8] = beats[i];
            s = s + {3'b000, beats[i]};
        end
        push_exp(d, (n > 4) ? 3'd4 : 3'(n), s, n > 4);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic l, output int w);
        logic rdy;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        w = 0;
        while (1'b1) begin
            @(negedge s_axis_aclk);
            rdy = s_axis_tready;
            @(posedge s_axis_aclk);
            if (rdy) break;
            w++;
            if (w >= BEAT_LIMIT) begin
                check("beat_accept_timeout", rdy, 1'b1);
                break;
            end
        end
        #1;
    endtask

    task automatic send_pkt(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge s_axis_aclk);
                    #1;
                end
            end
            send_beat(beats[i], i == n - 1, waits_a[i]);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_and_compare(input string tag, input bit chk_vc);
        int c;
        pkt_t g;
        pkt_t e;
        c = 0;
        while (got_q.size() < exp_q.size() && c < PKT_LIMIT) begin
            @(posedge s_axis_aclk);
            c++;
        end
        repeat (3) @(posedge s_axis_aclk);
        #1;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_data"}, g.data, e.data);
            check({tag, "_len"},  g.len,  e.len);
            check({tag, "_sum"},  g.sum,  e.sum);
            check({tag, "_err"},  g.err,  e.err);
            if (chk_vc) check({tag, "_valid_cycles"}, g.vc, 1);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        s_axis_areset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tlast  = 1'b0;
        pkt_ready     = 1'b0;
        rnd_done      = 1'b0;

        // Reset state
        repeat (3) @(posedge s_axis_aclk);
        @(negedge s_axis_aclk);
        check("rst_valid", pkt_valid, 1'b0);
        check("rst_data",  pkt_data,  32'h0);
        check("rst_len",   pkt_len,   3'd0);
        check("rst_sum",   pkt_sum,   11'd0);
        check("rst_err",   pkt_err,   1'b0);
        check("rst_tready", s_axis_tready, 1'b0);
        @(posedge s_axis_aclk);
        #1;
        s_axis_areset = 1'b0;
        @(negedge s_axis_aclk);
        check("post_rst_tready", s_axis_tready, 1'b1);
        @(posedge s_axis_aclk);
        #1;

        // Full 4-beat packet, consumer always ready
        pkt_ready = 1'b1;
        beats[0] = 8'h00; beats[1] = 8'h05; beats[2] = 8'h0A; beats[3] = 8'h0F;
        push_exp(32'h0F0A0500, 3'd4, 11'd30, 1'b0);
        send_pkt(4, 1'b0);
        @(negedge s_axis_aclk);
        check("latency_valid", pkt_valid, 1'b1);
        @(posedge s_axis_aclk);
        #1;
        wait_and_compare("full", 1'b1);

        // Short packet then single beat
        beats[0] = 8'h11; beats[1] = 8'h22;
        push_exp(32'h00002211, 3'd2, 11'h033, 1'b0);
        send_pkt(2, 1'b0);
        beats[0] = 8'hFF;
        push_exp(32'h000000FF, 3'd1, 11'h0FF, 1'b0);
        send_pkt(1, 1'b0);
        wait_and_compare("short", 1'b1);

        // Overflow: six beats, four stored
        for (int i = 0; i < 6; i++) beats[i] = 8'(i + 1);
        push_exp(32'h04030201, 3'd4, 11'd10, 1'b1);
        send_pkt(6, 1'b0);
        check("ovf_beat5_no_stall", waits_a[4], 0);
        check("ovf_beat6_no_stall", waits_a[5], 0);
        wait_and_compare("ovf", 1'b1);

        // Backpressure with next packet already waiting upstream
        pkt_ready = 1'b0;
        beats[0] = 8'hB1; beats[1] = 8'hB2; beats[2] = 8'hB3; beats[3] = 8'hB4;
        push_exp(32'hB4B3B2B1, 3'd4, 11'h2CA, 1'b0);
        send_pkt(4, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'hC1;
        s_axis_tlast  = 1'b0;
        repeat (5) begin
            @(negedge s_axis_aclk);
            check("bp_tready",   s_axis_tready, 1'b0);
            check("bp_valid",    pkt_valid, 1'b1);
            check("bp_data",     pkt_data,  32'hB4B3B2B1);
            check("bp_len",      pkt_len,   3'd4);
            check("bp_sum",      pkt_sum,   11'h2CA);
            check("bp_err",      pkt_err,   1'b0);
        end
        @(posedge s_axis_aclk);
        #1;
        pkt_ready = 1'b1;
        @(posedge s_axis_aclk);
        #1;
        @(negedge s_axis_aclk);
        check("bp_release_tready", s_axis_tready, 1'b1);
        check("bp_release_valid",  pkt_valid, 1'b0);
        check("bp_release_cleared", pkt_data, 32'h0);
        @(posedge s_axis_aclk);
        #1;
        s_axis_tvalid = 1'b0;
        @(negedge s_axis_aclk);
        check("bp_first_lane0", pkt_data, 32'h000000C1);
        @(posedge s_axis_aclk);
        #1;
        beats[0] = 8'hC2; beats[1] = 8'hC3; beats[2] = 8'hC4;
        push_exp(32'hC4C3C2C1, 3'd4, 11'h30A, 1'b0);
        send_pkt(3, 1'b0);
        wait_and_compare("bp", 1'b0);

        // Reset mid-packet
        send_beat(8'h55, 1'b0, waits_a[0]);
        send_beat(8'h66, 1'b0, waits_a[1]);
        s_axis_tvalid = 1'b0;
        s_axis_areset = 1'b1;
        @(negedge s_axis_aclk);
        check("midrst_tready_comb", s_axis_tready, 1'b0);
        @(posedge s_axis_aclk);
        #1;
        @(negedge s_axis_aclk);
        check("midrst_valid",  pkt_valid, 1'b0);
        check("midrst_data",   pkt_data,  32'h0);
        check("midrst_len",    pkt_len,   3'd0);
        check("midrst_sum",    pkt_sum,   11'd0);
        check("midrst_err",    pkt_err,   1'b0);
        check("midrst_tready", s_axis_tready, 1'b0);
        @(posedge s_axis_aclk);
        #1;
        s_axis_areset = 1'b0;
        beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3; beats[3] = 8'hA4;
        push_exp(32'hA4A3A2A1, 3'd4, 11'h28A, 1'b0);
        send_pkt(4, 1'b0);
        wait_and_compare("midrst", 1'b1);

        // Random valid gaps and consumer stalls, 1000 packets of 1..6 beats
        fork
            begin
                for (int p = 0; p < 1000; p++) begin
                    int n;
                    n = $urandom_range(1, 6);
                    for (int i = 0; i < n; i++) beats[i] = 8'($urandom_range(0, 255));
                    push_model(n);
                    send_pkt(n, 1'b1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge s_axis_aclk);
                    #1;
                    pkt_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        pkt_ready = 1'b1;
        wait_and_compare("rand", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
